counter_m10_seq: RTL and testbench
==================================

# counter_m10_seq

Command-driven sequencer for a two-digit cascaded mod-10 (BCD) up/down count, 00..99. It accepts "count N steps up/down" commands over a valid/ready handshake and steps the ones/tens digits at a programmable rate. It flags every ones-digit carry/borrow, signals completion, and sits between control logic and any display or compare logic consuming the BCD value.

## Interface
- STEP_DIV, default 1: clock cycles per step, legal range ≥1.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high together with cmd_valid; combinational `(state==IDLE) & ~clr`.
- cmd_dir  in  1  0 = count up, 1 = count down; sampled at accept.
- cmd_steps  in  7  number of steps; sampled at accept; values 100..127 are clamped to 99.
- clr  in  1  synchronous clear of both digits; honoured only in IDLE.
- q_ones  out  4  ones digit, BCD 0..9.
- q_tens  out  4  tens digit, BCD 0..9.
- c  out  1  one-cycle pulse on a step where the ones digit wraps (9→0 up, 0→9 down).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a command completes.
- sat  out  1  one-cycle saturation pulse (see Configuration).

## Operation
- States: IDLE, RUN. No other states.
- Reset (async) forces the following: state=IDLE, q_ones=0, q_tens=0, c=0, busy=0, done=0, sat=0, step and prescale counters=0.
- IDLE with clr=1: next edge sets both digits to 0. cmd_ready is low that cycle, so clr wins over a simultaneous command.
- Accept (IDLE, cmd_valid & cmd_ready): latch dir and clamped step count, clear the prescaler.
  - Nonzero count: go to RUN.
  - Zero count: stay IDLE and pulse done on the next edge. Digits and c are unchanged.
- RUN: the prescaler counts 0..STEP_DIV-1. When it reaches STEP_DIV-1, one step is executed and the remaining-step count decrements.
- Up step: ones 9→0 with c=1 and tens+1 (tens 9→0); otherwise ones+1.
- Down step: ones 0→9 with c=1 and tens−1 (tens 0→9); otherwise ones−1.
- Final step: same edge sets done=1 and state=IDLE, so cmd_ready is high the following cycle and back-to-back commands are allowed.
- clr, cmd_valid and all cmd_* inputs are ignored while in RUN.
- Digits never leave 0..9; all arithmetic is per-digit 4-bit.

## Timing
- Accept at edge N. Steps update the digits at edges N+k·STEP_DIV, for k = 1..steps.
- done, c and sat are registered and valid in the cycle after the edge that produced them. Each lasts exactly one cycle.
- busy rises at edge N and falls at the final-step edge.
- STEP_DIV=1: a step every cycle, so an M-step command occupies M cycles of busy.
- Reset mid-run aborts the command immediately: digits go to 00 and no done pulse is generated.

## Configuration
- Macro: COUNTER_M10_SAT_EN.
- Defined: an up step at 99 or a down step at 00 is not executed.
  - On that edge, digits hold, c=0, sat=1 and done=1.
  - The run terminates and the remaining steps are discarded.
- Undefined: counting wraps 99→00 (up) and 00→99 (down), with c=1 on that step. The sat port exists and is tied to 0.

## Test plan
- Reset: assert rst asynchronously mid-cycle → all outputs 0 immediately; after release, cmd_ready=1.
- Count up, STEP_DIV=1: from 00, steps=12 up → q=12 after 12 edges; c pulses once at the 09→10 step; done once on the 12th step edge; busy high for 12 cycles.
- Count down: from 12, steps=13 down → value passes 10→09 with c=1 and ends at 99 (wrap build) with c=1 at 00→99. In the COUNTER_M10_SAT_EN build it stops at 00 with sat=1 and done=1 on the 13th step edge.
- Rate and clamp: STEP_DIV=3, from 00, steps=120 up → clamped to 99 steps; first update 3 cycles after accept; final q=99; busy for 297 cycles.
- Handshake edge cases:
  - steps=0 → done next edge, q unchanged.
  - Back-to-back command accepted the cycle after done.
  - clr=1 together with cmd_valid in IDLE → q=00 and the command is not accepted.
  - cmd_valid during RUN is ignored.
- Reset mid-run: assert rst at step 5 of a 20-step command → q=00, no done; a new command afterwards runs normally from 00.

Source files
------------

// File: rtl/counter_m10_seq.sv
// Command-driven two-digit BCD up/down sequencer (00..99); COUNTER_M10_SAT_EN selects saturate at 99/00 instead of wrap.
// Latency: accept at edge N, digit updates at N+k*STEP_DIV; c/done/sat are registered one-cycle pulses.
// Backpressure: cmd_ready only in IDLE without clr; commands and clr are ignored while running.
module counter_m10_seq #(
    parameter int STEP_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_dir,
    input  logic [6:0] cmd_steps,
    input  logic       clr,
    output logic [3:0] q_ones,
    output logic [3:0] q_tens,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       sat
);

    localparam int            PW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);
    localparam logic [0:0]    IDLE     = 1'b0;
    localparam logic [0:0]    RUN      = 1'b1;
`ifdef COUNTER_M10_SAT_EN
    localparam logic          SAT_EN   = 1'b1;
`else
    localparam logic          SAT_EN   = 1'b0;
`endif

    logic [0:0]    state_q, state_d;
    logic          dir_q, dir_d;
    logic [6:0]    rem_q, rem_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic          c_q, c_d;
    logic          done_q, done_d;
    logic          sat_q, sat_d;

    logic [6:0]    steps_clamped;
    logic          at_limit;

    assign steps_clamped = (cmd_steps > 7'd99) ? 7'd99 : cmd_steps;
    assign at_limit      = dir_q ? (ones_q == 4'd0 && tens_q == 4'd0)
                                 : (ones_q == 4'd9 && tens_q == 4'd9);

    assign cmd_ready = (state_q == IDLE) & ~clr;
    assign busy      = (state_q == RUN);
    assign q_ones    = ones_q;
    assign q_tens    = tens_q;
    assign c         = c_q;
    assign done      = done_q;
    assign sat       = sat_q;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        pre_d   = pre_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        c_d     = 1'b0;
        done_d  = 1'b0;
        sat_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (clr) begin
                    ones_d = 4'd0;
                    tens_d = 4'd0;
                end else if (cmd_valid) begin
                    dir_d = cmd_dir;
                    rem_d = steps_clamped;
                    pre_d = '0;
                    if (steps_clamped == 7'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    rem_d = rem_q - 7'd1;
                    if (SAT_EN && at_limit) begin
                        // Blocked step: digits hold and the remaining count is dropped.
                        sat_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        if (!dir_q) begin
                            if (ones_q == 4'd9) begin
                                ones_d = 4'd0;
                                c_d    = 1'b1;
                                tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                            end else begin
                                ones_d = ones_q + 4'd1;
                            end
                        end else begin
                            if (ones_q == 4'd0) begin
                                ones_d = 4'd9;
                                c_d    = 1'b1;
                                tens_d = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
                            end else begin
                                ones_d = ones_q - 4'd1;
                            end
                        end
                        if (rem_q == 7'd1) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            pre_q   <= '0;
            ones_q  <= '0;
            tens_q  <= '0;
            c_q     <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            pre_q   <= pre_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            c_q     <= c_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_counter_m10_seq.sv
// Bench for counter_m10_seq: STEP_DIV=1 and STEP_DIV=3 instances share stimulus; a decimal model feeds per-instance scoreboards.
module tb_counter_m10_seq;

    typedef struct {
        int v;
        bit c;
        bit done;
        bit sat;
        bit busy;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_dir = 1'b0;
    logic [6:0] cmd_steps = '0;
    logic       clr = 1'b0;

    logic       rdy1, c1, busy1, done1, sat1;
    logic [3:0] ones1, tens1;
    logic       rdy3, c3, busy3, done3, sat3;
    logic [3:0] ones3, tens3;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mv = 0;
    ev_t sb1[$];
    ev_t sb3[$];
    int prev1 = 0;
    int prev3 = 0;

    counter_m10_seq #(.STEP_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .clr(clr),
        .q_ones(ones1), .q_tens(tens1), .c(c1), .busy(busy1), .done(done1), .sat(sat1)
    );

    counter_m10_seq #(.STEP_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy3),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .clr(clr),
        .q_ones(ones3), .q_tens(tens3), .c(c3), .busy(busy3), .done(done3), .sat(sat3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_ev(input string nm, input ev_t e, input ev_t a);
        vectors++;
        if (a.v != e.v || a.c != e.c || a.done != e.done || a.sat != e.sat ||
            a.busy != e.busy || a.cyc != e.cyc) begin
            miscompares++;
            $display("FAIL %s: got q=%0d c=%0b done=%0b sat=%0b busy=%0b cyc=%0d, expected q=%0d c=%0b done=%0b sat=%0b busy=%0b cyc=%0d",
                     nm, a.v, a.c, a.done, a.sat, a.busy, a.cyc, e.v, e.c, e.done, e.sat, e.busy, e.cyc);
        end
    endtask

    task automatic push_both(input ev_t e, input int k, input int n0);
        ev_t t;
        t = e;
        t.cyc = n0 + k;
        sb1.push_back(t);
        t.cyc = n0 + 3 * k;
        sb3.push_back(t);
    endtask

    // Reference: the count is a plain integer 0..99, one step = +/-1 modulo 100.
    task automatic model_cmd(input bit dir, input int steps, input int n0);
        int  n;
        ev_t e;
        n = (steps > 99) ? 99 : steps;
        if (n == 0) begin
            e = '{v: mv, c: 1'b0, done: 1'b1, sat: 1'b0, busy: 1'b0, cyc: 0};
            push_both(e, 0, n0);
            return;
        end
        for (int k = 1; k <= n; k++) begin
`ifdef COUNTER_M10_SAT_EN
            if ((!dir && mv == 99) || (dir && mv == 0)) begin
                e = '{v: mv, c: 1'b0, done: 1'b1, sat: 1'b1, busy: 1'b0, cyc: 0};
                push_both(e, k, n0);
                return;
            end
`endif
            e.c = dir ? (mv % 10 == 0) : (mv % 10 == 9);
            mv = dir ? (mv + 99) % 100 : (mv + 1) % 100;
            e.v = mv;
            e.done = (k == n);
            e.sat = 1'b0;
            e.busy = (k != n);
            push_both(e, k, n0);
        end
    endtask

    always @(negedge clk) begin
        ev_t a;
        ev_t e;
        a = '{v: tens1 * 10 + ones1, c: c1, done: done1, sat: sat1, busy: busy1, cyc: cyc};
        if (!rst) begin
            if (a.v != prev1 || a.c || a.done || a.sat) begin
                if (sb1.size() == 0) begin
                    chk("div1_unexpected_event_q", a.v, prev1 + 1000);
                end else begin
                    e = sb1.pop_front();
                    cmp_ev("div1_event", e, a);
                end
            end else if (sb1.size() > 0 && sb1[0].cyc < cyc) begin
                e = sb1.pop_front();
                chk("div1_missing_event_cyc", cyc, e.cyc);
            end
        end
        prev1 = a.v;
    end

    always @(negedge clk) begin
        ev_t a;
        ev_t e;
        a = '{v: tens3 * 10 + ones3, c: c3, done: done3, sat: sat3, busy: busy3, cyc: cyc};
        if (!rst) begin
            if (a.v != prev3 || a.c || a.done || a.sat) begin
                if (sb3.size() == 0) begin
                    chk("div3_unexpected_event_q", a.v, prev3 + 1000);
                end else begin
                    e = sb3.pop_front();
                    cmp_ev("div3_event", e, a);
                end
            end else if (sb3.size() > 0 && sb3[0].cyc < cyc) begin
                e = sb3.pop_front();
                chk("div3_missing_event_cyc", cyc, e.cyc);
            end
        end
        prev3 = a.v;
    end

    task automatic issue(input bit dir, input int steps);
        int n0;
        cmd_dir   = dir;
        cmd_steps = 7'(steps);
        cmd_valid = 1'b1;
        #1;
        chk("div1_cmd_ready", rdy1, 1);
        chk("div3_cmd_ready", rdy3, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n0 = cyc;
        model_cmd(dir, steps, n0);
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (sb1.size() == 0 && sb3.size() == 0 && !busy1 && !busy3) ok = 1'b1;
        end
        if (!ok) begin
            chk("wait_idle_timeout_pending", sb1.size() + sb3.size(), 0);
            sb1.delete();
            sb3.delete();
        end
    endtask

    initial begin
        #3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_q1", {24'd0, tens1, ones1}, 0);
        chk("reset_q3", {24'd0, tens3, ones3}, 0);
        chk("reset_flags1", {c1, busy1, done1, sat1}, 0);
        chk("reset_flags3", {c3, busy3, done3, sat3}, 0);
        rst = 1'b0;
        #1;
        chk("post_reset_ready1", rdy1, 1);
        chk("post_reset_ready3", rdy3, 1);

        issue(1'b0, 12);
        wait_idle(100);
        chk("up12_value", mv, 12);

        issue(1'b1, 13);
        wait_idle(100);

        // clr beats a simultaneous command
        clr = 1'b1;
        cmd_valid = 1'b1;
        cmd_dir = 1'b0;
        cmd_steps = 7'd5;
        #1;
        chk("clr_blocks_ready1", rdy1, 0);
        chk("clr_blocks_ready3", rdy3, 0);
        @(posedge clk);
        #1;
        if (mv != 0) push_both('{v: 0, c: 1'b0, done: 1'b0, sat: 1'b0, busy: 1'b0, cyc: 0}, 0, cyc);
        mv = 0;
        clr = 1'b0;
        cmd_valid = 1'b0;
        wait_idle(20);

        issue(1'b0, 120);
        wait_idle(400);
        chk("clamp_final_value", mv, 99);

        issue(1'b1, 0);
        wait_idle(20);

        issue(1'b0, 7);
        repeat (4) @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        clr = 1'b1;
        cmd_dir = 1'b1;
        cmd_steps = 7'd50;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        clr = 1'b0;
        wait_idle(100);

        for (int i = 0; i < 10; i++) begin
            int st;
            st = ($urandom_range(0, 4) == 0) ? $urandom_range(100, 127) : $urandom_range(0, 25);
            issue(1'($urandom_range(0, 1)), st);
            wait_idle(400);
        end

        // Reset in the middle of a 20-step run
        issue(1'b0, 20);
        repeat (15) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrun_reset_q1", {24'd0, tens1, ones1}, 0);
        chk("midrun_reset_q3", {24'd0, tens3, ones3}, 0);
        chk("midrun_reset_flags1", {c1, busy1, done1, sat1}, 0);
        chk("midrun_reset_flags3", {c3, busy3, done3, sat3}, 0);
        sb1.delete();
        sb3.delete();
        mv = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        issue(1'b0, 4);
        wait_idle(50);
        chk("after_reset_value", mv, 4);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
